// File: rtl/game_state_module_pkg.sv
// -----------------------------------------------------------------------------
// game_state_module_pkg
//   Shared definitions for the game controller. The state encoding is one-hot
//   and equals the screen-select vector {ready_sig, win_sig, over_sig, start},
//   so the VGA screen selector can use the same values as case labels.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package game_state_module_pkg;

   typedef enum logic [3:0] {
      ST_READY = 4'b1000,
      ST_WIN   = 4'b0100,
      ST_OVER  = 4'b0010,
      ST_PLAY  = 4'b0001
   } state_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/game_state_module_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce_module
//   Synchronises a raw push-button level, debounces it and emits a one-cycle
//   pulse on each debounced 0->1 edge.
//   Ports:
//     CLK       in  system clock
//     RST       in  asynchronous, active-high reset
//     key_in    in  raw key level, asynchronous, 1 = pressed
//     key_press out registered 1-cycle pulse on debounced press
// -----------------------------------------------------------------------------
module key_debounce_module
   import game_state_module_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_in,
   output logic key_press
);

   localparam int unsigned          CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_deb;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   // The counter runs only while the synchronised level disagrees with the
   // debounced level; any return to agreement restarts the stability window.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= key_in;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_deb   <= r_sync2;
            r_cnt   <= '0;
            r_press <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign key_press = r_press;

endmodule

// File: rtl/game_state_module.sv
// -----------------------------------------------------------------------------
// game_state_module
//   Top-level game controller. Tracks the game phase READY/PLAY/WIN/OVER and
//   drives the one-hot screen select {ready_sig, win_sig, over_sig, start}.
//   Issues a one-cycle game_rst pulse on entry to PLAY.
//   Ports:
//     CLK        in  system clock
//     RST        in  asynchronous, active-high reset
//     key_start  in  raw start key level, asynchronous, 1 = pressed
//     hit_wall   in  1-cycle pulse, head left the play field
//     hit_body   in  1-cycle pulse, head overlapped body
//     snake_len  in  current snake length, unsigned, LEN_W bits
//     ready_sig  out READY screen select
//     start      out PLAY screen select / snake logic enable
//     win_sig    out WIN screen select
//     over_sig   out OVER screen select
//     game_rst   out 1-cycle pulse coincident with start first reading 1
// -----------------------------------------------------------------------------
module game_state_module
   import game_state_module_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned HOLD_CYCLES     = 100_000_000,
   parameter int unsigned LEN_W           = 6,
   parameter int unsigned WIN_LEN         = 20
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             key_start,
   input  logic             hit_wall,
   input  logic             hit_body,
   input  logic [LEN_W-1:0] snake_len,
   output logic             ready_sig,
   output logic             start,
   output logic             win_sig,
   output logic             over_sig,
   output logic             game_rst
);

   localparam int unsigned          HOLD_W   = cnt_width(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [LEN_W-1:0]     WIN_LEN_V = LEN_W'(WIN_LEN);

   state_t              r_state;
   state_t              w_next;
   logic [HOLD_W-1:0]   r_hold;
   logic                r_game_rst;
   logic                w_key_press;
   logic                w_hold_done;
   logic                w_end_screen;

   key_debounce_module #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .CLK       (CLK),
      .RST       (RST),
      .key_in    (key_start),
      .key_press (w_key_press)
   );

   assign w_hold_done  = (r_hold == HOLD_MAX);
   assign w_end_screen = (r_state == ST_WIN) || (r_state == ST_OVER);

   // Next-state logic; a failure takes priority over reaching the win length.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_READY: if (w_key_press) w_next = ST_PLAY;
         ST_PLAY: begin
            if (hit_wall || hit_body)        w_next = ST_OVER;
            else if (snake_len >= WIN_LEN_V) w_next = ST_WIN;
         end
         ST_WIN,
         ST_OVER:  if (w_key_press && w_hold_done) w_next = ST_READY;
         default:  w_next = ST_READY;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= ST_READY;
      else     r_state <= w_next;
   end

   // Hold counter restarts on every state change and only runs on the
   // WIN/OVER screens, saturating once the minimum display time has passed.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_hold <= '0;
      end else if (w_next != r_state) begin
         r_hold <= '0;
      end else if (w_end_screen && !w_hold_done) begin
         r_hold <= r_hold + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_game_rst <= 1'b0;
      else     r_game_rst <= (r_state == ST_READY) && (w_next == ST_PLAY);
   end

   assign {ready_sig, win_sig, over_sig, start} = r_state;
   assign game_rst = r_game_rst;

endmodule
